// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one synchronous FIFO between NUM_REQ producers.
// One producer holds the grant at a time for a burst of up to MAX_BURST words.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned IdWidth   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_valid,
  output logic [IdWidth-1:0]            grant_id,
  output logic [CNT_WIDTH-1:0]          wr_count
);

  localparam int unsigned BurstWidth = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BurstWidth-1:0] BurstLast = BurstWidth'(MAX_BURST - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                state_q, state_d;
  logic [IdWidth-1:0]    grant_id_q, grant_id_d;
  logic [IdWidth-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BurstWidth-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_count_q;

  logic                  grant_active;
  logic                  accept;
  logic                  pick_found;
  logic [IdWidth-1:0]    pick_id;
  logic [IdWidth-1:0]    scan_idx;

  assign grant_active = (state_q == StGrant);
  // Reset gates the write strobe so nothing lands in the FIFO during the reset cycle.
  assign accept = grant_active && req_valid[grant_id_q] && !fifo_full && !rst;

  // First valid requester strictly after the last grant holder, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IdWidth'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d     = StGrant;
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
        end
      end
      StGrant: begin
        if (!req_valid[grant_id_q] || (accept && (burst_cnt_q == BurstLast))) begin
          state_d  = StIdle;
          rr_ptr_d = grant_id_q;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + BurstWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= IdWidth'(NUM_REQ - 1);
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      if (accept) begin
        wr_count_q <= wr_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_active && !fifo_full && !rst) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  assign fifo_wr_en   = accept;
  assign fifo_cs      = accept;
  assign fifo_data_in = grant_active ? req_data[32'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH]
                                     : '0;
  assign grant_valid  = grant_active;
  assign grant_id     = grant_id_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level arbiter model, with a depth-8 FIFO modelled as a queue.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned FifoDepth = 8;
  localparam int unsigned SrcSize = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          fifo_full = 1'b0;
  logic          fifo_cs;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic [CW-1:0] wr_count;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_cs     (fifo_cs),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .wr_count    (wr_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Producer word queues as rings; head advances when a word is accepted.
  logic [DW-1:0] src_mem [NR][SrcSize];
  int unsigned   src_head [NR];
  int unsigned   src_tail [NR];
  logic [DW-1:0] fifo_q [$];
  int            glog [$];

  logic          rst_cmd = 1'b1;
  logic          rd_cmd = 1'b0;
  logic          rd_en = 1'b0;
  bit            rand_mode = 1'b0;
  logic [NR-1:0] took_n = '0;
  logic          pend_wr = 1'b0;
  logic          pend_rd = 1'b0;
  logic          pend_rst = 1'b1;
  logic [DW-1:0] pend_d = '0;
  logic          prev_gv = 1'b0;

  task automatic src_push(input int i, input logic [DW-1:0] d);
    src_mem[i][src_tail[i] % SrcSize] = d;
    src_tail[i]++;
  endtask

  // All stimulus and FIFO-side updates happen just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (pend_rst) begin
      fifo_q.delete();
    end else begin
      if (pend_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (pend_wr) fifo_q.push_back(pend_d);
    end
    fifo_full = (fifo_q.size() >= FifoDepth);
    for (int i = 0; i < NR; i++) begin
      if (took_n[i] && src_head[i] != src_tail[i]) src_head[i]++;
      if (rand_mode && (src_tail[i] - src_head[i]) < 2 && $urandom_range(3) == 0)
        src_push(i, $urandom);
      req_valid[i] = (src_head[i] != src_tail[i]) && !(rand_mode && $urandom_range(7) == 0);
      req_data[i*DW +: DW] = src_mem[i][src_head[i] % SrcSize];
    end
    rst   = rst_cmd;
    rd_en = rand_mode ? ($urandom_range(2) != 0) : rd_cmd;
  end

  // Reference model: who holds the grant, how many words it has written,
  // who held it last, and the total words written.
  bit            model_ok = 1'b0;
  bit            m_busy = 1'b0;
  int            m_owner = 0;
  int            m_words = 0;
  int            m_last = NR - 1;
  int unsigned   m_total = 0;
  logic [NR-1:0] exp_ready;
  logic          exp_acc;
  logic [DW-1:0] exp_data;
  int            cand;

  always @(negedge clk) begin
    took_n   = req_ready & req_valid;
    pend_wr  = fifo_wr_en;
    pend_d   = fifo_data_in;
    pend_rd  = rd_en;
    pend_rst = rst;
    if (grant_valid && !prev_gv) glog.push_back(int'(grant_id));
    prev_gv = grant_valid;

    exp_ready = '0;
    if (m_busy && !fifo_full && !rst) exp_ready[m_owner] = 1'b1;
    exp_acc  = m_busy && req_valid[m_owner] && !fifo_full && !rst;
    exp_data = m_busy ? req_data[m_owner*DW +: DW] : '0;
    if (model_ok) begin
      check("grant_valid", 64'(grant_valid), 64'(m_busy));
      check("grant_id", 64'(grant_id), 64'(m_owner));
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_acc));
      check("fifo_cs", 64'(fifo_cs), 64'(exp_acc));
      check("fifo_data_in", 64'(fifo_data_in), 64'(exp_data));
      check("wr_count", 64'(wr_count), 64'(m_total % (2 ** CW)));
      check("wr_while_full", 64'(fifo_wr_en & fifo_full), 64'(0));
    end

    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_words = 0; m_last = NR - 1; m_total = 0;
      model_ok = 1'b1;
    end else if (!m_busy) begin
      for (int k = 1; k <= NR; k++) begin
        cand = (m_last + k) % NR;
        if (!m_busy && req_valid[cand]) begin
          m_busy = 1'b1; m_owner = cand; m_words = 0;
        end
      end
    end else begin
      if (exp_acc) begin
        m_total++;
        m_words++;
      end
      if (!req_valid[m_owner] || m_words == MB) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    for (int i = 0; i < NR; i++) src_head[i] = src_tail[i];
    tick(2);
    rst_cmd = 1'b0;
    tick(1);
    glog.delete();
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit done;
    done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      done = !grant_valid;
      for (int i = 0; i < NR; i++) if (src_head[i] != src_tail[i]) done = 1'b0;
      if (!done) tick(1);
    end
    check(name, 64'(done), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    tick(1);
    do_reset();
    check("rst_grant_valid", 64'(grant_valid), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_fifo_cs", 64'(fifo_cs), 64'(0));
    check("rst_fifo_data_in", 64'(fifo_data_in), 64'(0));
    check("rst_wr_count", 64'(wr_count), 64'(0));

    // Single requester, three held words, then valid drops.
    src_push(0, 1); src_push(0, 10); src_push(0, 100);
    tick(2);
    check("s1_grant_valid", 64'(grant_valid), 64'(1));
    check("s1_grant_id", 64'(grant_id), 64'(0));
    tick(5);
    check("s1_wr_count", 64'(wr_count), 64'(3));
    check("s1_released", 64'(grant_valid), 64'(0));
    check("s1_fifo_size", 64'(fifo_q.size()), 64'(3));
    check("s1_word0", 64'(fifo_q[0]), 64'(1));
    check("s1_word1", 64'(fifo_q[1]), 64'(10));
    check("s1_word2", 64'(fifo_q[2]), 64'(100));

    // All four streaming: strict rotation with 4-word bursts and a bubble.
    do_reset();
    rd_cmd = 1'b1;
    for (int i = 0; i < NR; i++) for (int k = 0; k < 8; k++) src_push(i, 1 << i);
    tick(21);
    check("s2_wr_count", 64'(wr_count), 64'(16));
    tick(1);
    check("s2_grants", 64'(glog.size()), 64'(5));
    check("s2_order0", 64'(glog[0]), 64'(0));
    check("s2_order1", 64'(glog[1]), 64'(1));
    check("s2_order2", 64'(glog[2]), 64'(2));
    check("s2_order3", 64'(glog[3]), 64'(3));
    check("s2_order4", 64'(glog[4]), 64'(0));

    // Lone requester with six words: 4-word burst, bubble, 2-word burst.
    do_reset();
    for (int k = 0; k < 6; k++) src_push(2, 200 + k);
    tick(6);
    check("s3_bubble", 64'(grant_valid), 64'(0));
    check("s3_first_burst", 64'(wr_count), 64'(4));
    wait_idle("s3_drain", 60);
    check("s3_wr_count", 64'(wr_count), 64'(6));
    check("s3_grants", 64'(glog.size()), 64'(2));
    check("s3_regrant", 64'(glog[1]), 64'(2));

    // FIFO fills with no reads; one read lets exactly one more word in.
    do_reset();
    rd_cmd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      src_push(0, 100 + k);
      src_push(1, 300 + k);
    end
    tick(20);
    check("s4_fifo_size", 64'(fifo_q.size()), 64'(8));
    check("s4_wr_count", 64'(wr_count), 64'(8));
    check("s4_full", 64'(fifo_full), 64'(1));
    check("s4_grant_held", 64'(grant_valid), 64'(1));
    check("s4_grant_id", 64'(grant_id), 64'(0));
    check("s4_ready_low", 64'(req_ready), 64'(0));
    rd_cmd = 1'b1;
    tick(1);
    rd_cmd = 1'b0;
    tick(5);
    check("s4_one_more", 64'(wr_count), 64'(9));
    check("s4_refull", 64'(fifo_q.size()), 64'(8));

    // Reset during the second word of a burst from requester 3.
    do_reset();
    rd_cmd = 1'b1;
    for (int k = 0; k < 4; k++) src_push(3, 30 + k);
    tick(2);
    src_push(0, 40); src_push(0, 41);
    rst_cmd = 1'b1;
    tick(1);
    rst_cmd = 1'b0;
    tick(1);
    check("s5_idle", 64'(grant_valid), 64'(0));
    check("s5_ready", 64'(req_ready), 64'(0));
    check("s5_wr_count", 64'(wr_count), 64'(0));
    tick(1);
    check("s5_grant_valid", 64'(grant_valid), 64'(1));
    check("s5_winner", 64'(grant_id), 64'(0));
    wait_idle("s5_drain", 60);
    check("s5_total", 64'(wr_count), 64'(5));

    // Write counter wraps modulo 2**CW.
    do_reset();
    for (int k = 0; k < (1 << CW) + 2; k++) src_push(1, k);
    wait_idle("s6_drain", 1000);
    check("s6_wrap", 64'(wr_count), 64'(2));

    // Random traffic, random reads and valid drops, with a reset midway.
    do_reset();
    rand_mode = 1'b1;
    tick(1500);
    do_reset();
    tick(1500);
    rand_mode = 1'b0;
    rd_cmd = 1'b1;
    wait_idle("rand_drain", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
